// File: rtl/contador_param.sv
// Parameterised modulo counter: programmable TOP, configurable up-step,
// wrap or saturate at the limits, and a cascade enable for chaining stages.
module contador_param #(
    parameter int WIDTH   = 4,
    parameter int TOP     = (1 << WIDTH) - 1,
    parameter int STEP_UP = 3,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    localparam logic [WIDTH:0] TOP_X  = (WIDTH+1)'(TOP);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP_UP);
    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] SPAN_X = (WIDTH+1)'(TOP + 1);

    // Results are packed as {limit_hit, next_q}; the extra bit keeps Q+s
    // from overflowing before it is compared against TOP.
    function automatic logic [WIDTH:0] count_up(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH:0]   s);
        logic [WIDTH:0] sum;
        sum = {1'b0, q} + s;
        if (sum <= TOP_X) begin
            count_up = sum;
        end else if (WRAP != 0) begin
            count_up = sum - SPAN_X;
            count_up[WIDTH] = 1'b1;
        end else begin
            count_up = {1'b1, TOP_X[WIDTH-1:0]};
        end
    endfunction

    function automatic logic [WIDTH:0] count_down(input logic [WIDTH-1:0] q);
        if (q != '0) begin
            count_down = {1'b0, q - WIDTH'(1)};
        end else if (WRAP != 0) begin
            count_down = {1'b1, TOP_X[WIDTH-1:0]};
        end else begin
            count_down = {1'b1, {WIDTH{1'b0}}};
        end
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
        if ({1'b0, d} > TOP_X) begin
            clamp_load = TOP_X[WIDTH-1:0];
        end else begin
            clamp_load = d;
        end
    endfunction

    logic [WIDTH:0] step_res;

    always_comb begin
        step_res = count_up(Q, ONE_X);
        case (mode)
            2'b00:   step_res = count_up(Q, STEP_X);
            2'b01:   step_res = count_down(Q);
            default: step_res = count_up(Q, ONE_X);
        endcase
    end

    // Output register stage: every output is registered, one cycle after inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else if (enable && cin) begin
            if (mode == 2'b11) begin
                Q    <= clamp_load(D);
                rco  <= 1'b0;
                load <= 1'b1;
            end else begin
                Q    <= step_res[WIDTH-1:0];
                rco  <= step_res[WIDTH];
                load <= 1'b0;
            end
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// Directed, table-driven bench for contador_param across wrap, saturate,
// load-clamp, hold, asynchronous reset and two-stage cascade configurations.
module tb_contador_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ci  = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] d   = 4'd0;

    logic [3:0] qa, qb, qc, q_lo, q_hi;
    logic       rco_a, rco_b, rco_c, rco_lo, rco_hi;
    logic       ld_a, ld_b, ld_c, ld_lo, ld_hi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(4)) dut_a (
        .clk(clk), .reset(rst), .enable(en), .cin(ci), .mode(mode), .D(d),
        .Q(qa), .rco(rco_a), .load(ld_a));

    contador_param #(.WIDTH(4), .TOP(9), .STEP_UP(3), .WRAP(1)) dut_b (
        .clk(clk), .reset(rst), .enable(en), .cin(ci), .mode(mode), .D(d),
        .Q(qb), .rco(rco_b), .load(ld_b));

    contador_param #(.WIDTH(4), .TOP(9), .STEP_UP(3), .WRAP(0)) dut_c (
        .clk(clk), .reset(rst), .enable(en), .cin(ci), .mode(mode), .D(d),
        .Q(qc), .rco(rco_c), .load(ld_c));

    contador_param #(.WIDTH(4), .TOP(9), .STEP_UP(3), .WRAP(1)) dut_lo (
        .clk(clk), .reset(rst), .enable(en), .cin(ci), .mode(mode), .D(d),
        .Q(q_lo), .rco(rco_lo), .load(ld_lo));

    contador_param #(.WIDTH(4), .TOP(9), .STEP_UP(3), .WRAP(1)) dut_hi (
        .clk(clk), .reset(rst), .enable(en), .cin(rco_lo), .mode(mode), .D(d),
        .Q(q_hi), .rco(rco_hi), .load(ld_hi));

    typedef struct {
        int         sel;
        logic       rst;
        logic       en;
        logic       ci;
        logic [1:0] mode;
        logic [3:0] d;
        logic [3:0] q;
        logic       rco;
        logic       ld;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int sel, input logic r, input logic e,
                                input logic c, input logic [1:0] m,
                                input logic [3:0] dv, input logic [3:0] q,
                                input logic rc, input logic l);
        vec_t v;
        v.sel = sel; v.rst = r; v.en = e; v.ci = c; v.mode = m; v.d = dv;
        v.q = q; v.rco = rc; v.ld = l;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] aq;
        logic       ar, al;

        // 4-bit, TOP=15: count up by one through the wrap
        add(0, 1, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0);
        for (int i = 1; i <= 17; i++)
            add(0, 0, 1, 1, 2'b10, 4'd0,
                (i == 16) ? 4'd0 : (i == 17) ? 4'd1 : 4'(i), i == 16, 0);
        // step-by-3 across the wrap, exact hit on TOP, then wrap again
        add(0, 0, 1, 1, 2'b11, 4'd13, 4'd13, 0, 1);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd0,  1, 0);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd3,  0, 0);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd6,  0, 0);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd9,  0, 0);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd12, 0, 0);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd15, 0, 0);
        add(0, 0, 1, 1, 2'b00, 4'd0,  4'd2,  1, 0);
        add(0, 0, 0, 1, 2'b00, 4'd0,  4'd2,  0, 0);

        // TOP=9 wrap: load clamp, count down through the wrap
        add(1, 1, 0, 0, 2'b00, 4'd0,  4'd0, 0, 0);
        add(1, 0, 1, 1, 2'b11, 4'd12, 4'd9, 0, 1);
        for (int i = 8; i >= 0; i--)
            add(1, 0, 1, 1, 2'b01, 4'd0, 4'(i), 0, 0);
        add(1, 0, 1, 1, 2'b01, 4'd0, 4'd9, 1, 0);
        add(1, 0, 1, 1, 2'b11, 4'd9, 4'd9, 0, 1);
        add(1, 0, 1, 1, 2'b11, 4'd5, 4'd5, 0, 1);
        // hold with enable or cin low; mode and D ignored
        add(1, 0, 1, 1, 2'b10, 4'd0, 4'd6, 0, 0);
        add(1, 0, 0, 1, 2'b11, 4'd3, 4'd6, 0, 0);
        add(1, 0, 1, 0, 2'b11, 4'd3, 4'd6, 0, 0);
        add(1, 0, 1, 1, 2'b10, 4'd3, 4'd7, 0, 0);

        // TOP=9 saturate at both limits
        add(2, 1, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0);
        add(2, 0, 1, 1, 2'b11, 4'd8, 4'd8, 0, 1);
        add(2, 0, 1, 1, 2'b10, 4'd0, 4'd9, 0, 0);
        add(2, 0, 1, 1, 2'b10, 4'd0, 4'd9, 1, 0);
        add(2, 0, 1, 1, 2'b10, 4'd0, 4'd9, 1, 0);
        add(2, 0, 1, 1, 2'b00, 4'd0, 4'd9, 1, 0);
        add(2, 0, 0, 1, 2'b00, 4'd0, 4'd9, 0, 0);
        add(2, 0, 1, 1, 2'b11, 4'd0, 4'd0, 0, 1);
        add(2, 0, 1, 1, 2'b01, 4'd0, 4'd0, 1, 0);
        add(2, 0, 1, 1, 2'b01, 4'd0, 4'd0, 1, 0);
        add(2, 0, 1, 1, 2'b10, 4'd0, 4'd1, 0, 0);
        add(2, 0, 1, 1, 2'b11, 4'd8, 4'd8, 0, 1);
        add(2, 0, 1, 1, 2'b00, 4'd0, 4'd9, 1, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; ci = vecs[i].ci;
            mode = vecs[i].mode; d = vecs[i].d;
            @(posedge clk);
            #1;
            case (vecs[i].sel)
                0:       begin aq = qa; ar = rco_a; al = ld_a; end
                1:       begin aq = qb; ar = rco_b; al = ld_b; end
                default: begin aq = qc; ar = rco_c; al = ld_c; end
            endcase
            check($sformatf("vec%0d_dut%0d_q",    i, vecs[i].sel), 32'(aq), 32'(vecs[i].q));
            check($sformatf("vec%0d_dut%0d_rco",  i, vecs[i].sel), 32'(ar), 32'(vecs[i].rco));
            check($sformatf("vec%0d_dut%0d_load", i, vecs[i].sel), 32'(al), 32'(vecs[i].ld));
        end

        // asynchronous reset pulsed between edges
        rst = 1'b0; en = 1'b1; ci = 1'b1; mode = 2'b11; d = 4'd11;
        @(posedge clk);
        #1;
        check("async_pre_q", 32'(qa), 32'd11);
        check("async_pre_load", 32'(ld_a), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_q", 32'(qa), 32'd0);
        check("async_rco", 32'(rco_a), 32'd0);
        check("async_load", 32'(ld_a), 32'd0);
        rst = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        check("async_hold_q", 32'(qa), 32'd0);

        // two-stage cascade, TOP=9 per stage
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b1; ci = 1'b1; mode = 2'b10; d = 4'd0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                check("casc_c10_lo_rco", 32'(rco_lo), 32'd1);
                check("casc_c10_hi_q", 32'(q_hi), 32'd0);
            end
            if (i == 11) begin
                check("casc_c11_lo_rco", 32'(rco_lo), 32'd0);
                check("casc_c11_hi_q", 32'(q_hi), 32'd1);
            end
        end
        check("casc_lo_q", 32'(q_lo), 32'd5);
        check("casc_hi_q", 32'(q_hi), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
